// File: rtl/chain_pkg.sv
// Shared types and constants for the anchor chaining score pipeline.
package chain_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam int FRAC_W = 8;

    // 64-bit extremes; narrower datapaths derive their limits by arithmetic shift.
    localparam logic signed [63:0] POS_INF = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [63:0] NEG_INF = 64'sh8000_0000_0000_0000;

endpackage

// File: rtl/chain_gap_cost.sv
// Gap penalty: ((dd * coef) >> FRAC_W) + (floor_log2(dd) >> 1), with floor_log2(0) = 0.
module chain_gap_cost
    import chain_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  dd,
    input  logic [15:0]       coef,
    output logic [WIDTH+8:0]  gap
);

    localparam int LW = $clog2(WIDTH);

    logic [WIDTH+15:0] prod;
    logic [LW-1:0]     lg;

    assign prod = dd * coef;

    // Priority encoder: the highest set bit wins because later iterations overwrite.
    always_comb begin
        lg = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dd[i]) lg = LW'(i);
        end
    end

    assign gap = (WIDTH+9)'(prod >> FRAC_W) + (WIDTH+9)'(lg >> 1);

endmodule

// File: rtl/chain_score_pipe.sv
// Scores one anchor against up to NPRED_MAX predecessors through a 3-stage pipeline
// and reports the best chain score, its predecessor index and whether any beat won.
module chain_score_pipe
    import chain_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NPRED_MAX = 64,
    parameter int MAX_DIST  = 5000,
    parameter int BW        = 500
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cur_valid,
    output logic                              cur_ready,
    input  logic signed [WIDTH-1:0]           cur_rx,
    input  logic signed [WIDTH-1:0]           cur_qy,
    input  logic signed [WIDTH-1:0]           cur_w,
    input  logic [$clog2(NPRED_MAX+1)-1:0]    cur_npred,
    input  logic [15:0]                       gap_coef,
    input  logic                              pred_valid,
    output logic                              pred_ready,
    input  logic signed [WIDTH-1:0]           pred_rx,
    input  logic signed [WIDTH-1:0]           pred_qy,
    input  logic signed [WIDTH-1:0]           pred_f,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic signed [WIDTH-1:0]           res_score,
    output logic [$clog2(NPRED_MAX)-1:0]      res_idx,
    output logic                              res_found
);

    localparam int NW = $clog2(NPRED_MAX+1);
    localparam int IW = $clog2(NPRED_MAX);
    localparam int CW = WIDTH + 11;

    localparam logic signed [WIDTH-1:0] SAT_MAX  = WIDTH'(POS_INF >>> (64 - WIDTH));
    localparam logic signed [CW-1:0]    CAND_MAX = CW'(POS_INF >>> (64 - WIDTH));
    localparam logic signed [CW-1:0]    CAND_MIN = CW'(NEG_INF >>> (64 - WIDTH));
    localparam logic signed [WIDTH:0]   DIST_MAX = (WIDTH+1)'(MAX_DIST);
    localparam logic [WIDTH+1:0]        BAND_MAX = (WIDTH+2)'(BW);
    localparam logic [NW-1:0]           NPRED_CAP = NW'(NPRED_MAX);

    function automatic logic signed [WIDTH-1:0] sat_cand(input logic signed [CW-1:0] x);
        if (x > CAND_MAX)      return SAT_MAX;
        else if (x < CAND_MIN) return WIDTH'(CAND_MIN);
        else                   return x[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH:0] min3(input logic signed [WIDTH:0] a,
                                                   input logic signed [WIDTH:0] b,
                                                   input logic signed [WIDTH:0] c);
        logic signed [WIDTH:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    state_t                  state, state_n;
    logic                    live;
    logic [NW-1:0]           count, npred_r, npred_c;
    logic signed [WIDTH-1:0] rx_r, qy_r, w_r;
    logic [15:0]             coef_r;
    logic signed [WIDTH-1:0] best;
    logic [IW-1:0]           best_idx;
    logic                    found, empty_q;
    logic                    cur_fire, pred_fire, last_beat;

    logic                    vld_p1;
    logic signed [WIDTH:0]   dr_p1, dq_p1;
    logic signed [WIDTH-1:0] f_p1;
    logic [IW-1:0]           idx_p1;

    logic signed [WIDTH+1:0] dr_x, dq_x, diff;
    logic [WIDTH+1:0]        dd_mag;
    logic                    ok_s2;
    logic signed [WIDTH:0]   sc_s2;
    logic [WIDTH+8:0]        gap_s2;

    logic                    vld_p2, ok_p2;
    logic signed [WIDTH:0]   sc_p2;
    logic [WIDTH+8:0]        gap_p2;
    logic signed [WIDTH-1:0] f_p2;
    logic [IW-1:0]           idx_p2;

    logic signed [CW-1:0]    cand_wide;
    logic signed [WIDTH-1:0] cand;
    logic                    take;

    assign cur_ready  = live && (state == IDLE);
    assign pred_ready = (state == ACCUM) && (count < npred_r);
    assign cur_fire   = cur_valid && cur_ready;
    assign pred_fire  = pred_valid && pred_ready;
    assign last_beat  = pred_fire && (count == npred_r - 1'b1);
    assign npred_c    = (cur_npred > NPRED_CAP) ? NPRED_CAP : cur_npred;

    assign res_valid = (state == OUT);
    assign res_score = best;
    assign res_found = found;
    assign res_idx   = (res_valid && !found) ? '1 : best_idx;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cur_fire) state_n = (npred_c == '0) ? DRAIN : ACCUM;
            ACCUM:   if (last_beat) state_n = DRAIN;
            DRAIN:   if (empty_q) state_n = OUT;
            OUT:     if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // empty_q lags the pipeline by one cycle so DRAIN always spans the S3 write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            live     <= 1'b0;
            count    <= '0;
            npred_r  <= '0;
            best     <= '0;
            best_idx <= '0;
            found    <= 1'b0;
            empty_q  <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            state   <= state_n;
            live    <= 1'b1;
            vld_p1  <= pred_fire;
            vld_p2  <= vld_p1;
            empty_q <= (state == DRAIN) && !vld_p1 && !vld_p2;
            if (cur_fire) begin
                count   <= '0;
                npred_r <= npred_c;
                best    <= cur_w;
                found   <= 1'b0;
            end else begin
                if (pred_fire) count <= count + 1'b1;
                if (take) begin
                    best     <= cand;
                    best_idx <= idx_p2;
                    found    <= 1'b1;
                end
            end
        end
    end

    // ---- S1: coordinate deltas ----
    always_ff @(posedge clk) begin
        if (cur_fire) begin
            rx_r   <= cur_rx;
            qy_r   <= cur_qy;
            w_r    <= cur_w;
            coef_r <= gap_coef;
        end
        dr_p1  <= {rx_r[WIDTH-1], rx_r} - {pred_rx[WIDTH-1], pred_rx};
        dq_p1  <= {qy_r[WIDTH-1], qy_r} - {pred_qy[WIDTH-1], pred_qy};
        f_p1   <= pred_f;
        idx_p1 <= count[IW-1:0];
    end

    // ---- S2: validity, span score and gap cost ----
    assign dr_x   = {dr_p1[WIDTH], dr_p1};
    assign dq_x   = {dq_p1[WIDTH], dq_p1};
    assign diff   = dr_x - dq_x;
    assign dd_mag = diff[WIDTH+1] ? -diff : diff;
    assign ok_s2  = !dr_p1[WIDTH] && (dr_p1 != '0) && !dq_p1[WIDTH] && (dq_p1 != '0) &&
                    (dr_p1 <= DIST_MAX) && (dq_p1 <= DIST_MAX) && (dd_mag <= BAND_MAX);
    assign sc_s2  = min3(dr_p1, dq_p1, {w_r[WIDTH-1], w_r});

    chain_gap_cost #(.WIDTH(WIDTH)) u_gap (
        .dd   (dd_mag[WIDTH-1:0]),
        .coef (coef_r),
        .gap  (gap_s2)
    );

    always_ff @(posedge clk) begin
        ok_p2  <= ok_s2;
        sc_p2  <= sc_s2;
        gap_p2 <= gap_s2;
        f_p2   <= f_p1;
        idx_p2 <= idx_p1;
    end

    // ---- S3: saturated candidate and best update ----
    assign cand_wide = {{11{f_p2[WIDTH-1]}}, f_p2} + {{10{sc_p2[WIDTH]}}, sc_p2} - {2'b00, gap_p2};
    assign cand      = sat_cand(cand_wide);
    assign take      = vld_p2 && ok_p2 && (cand > best);

endmodule

// File: tb/tb_chain_score_pipe.sv
// Bench for chain_score_pipe: directed vector table, backpressure/reset sequences,
// and randomized anchors scored by an arithmetic reference model.
module tb_chain_score_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cur_valid, cur_ready;
    logic signed [31:0] cur_rx, cur_qy, cur_w;
    logic [6:0]         cur_npred;
    logic [15:0]        gap_coef;
    logic               pred_valid, pred_ready;
    logic signed [31:0] pred_rx, pred_qy, pred_f;
    logic               res_valid, res_ready;
    logic signed [31:0] res_score;
    logic [5:0]         res_idx;
    logic               res_found;

    int checks = 0;
    int errors = 0;

    int a_rx, a_qy, a_w, a_coef, a_np;
    int prx[64], pqy[64], pf[64];

    typedef struct {
        int rx, qy, w, coef, np;
        int x0, y0, f0, x1, y1, f1, x2, y2, f2;
        longint es;
        int ei, ef, el;
    } vec_t;

    vec_t tbl[9];

    chain_score_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .cur_valid(cur_valid), .cur_ready(cur_ready),
        .cur_rx(cur_rx), .cur_qy(cur_qy), .cur_w(cur_w), .cur_npred(cur_npred),
        .gap_coef(gap_coef),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .pred_rx(pred_rx), .pred_qy(pred_qy), .pred_f(pred_f),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_idx(res_idx), .res_found(res_found)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int flog2(input longint v);
        longint t = v;
        int l = 0;
        while (t > 1) begin
            t = t >> 1;
            l++;
        end
        return l;
    endfunction

    task automatic model(output longint s, output int idx, output int fnd);
        longint best, dr, dq, dd, sc, gap, cand;
        int nb;
        best = a_w;
        idx = 63;
        fnd = 0;
        nb = (a_np > 64) ? 64 : a_np;
        for (int j = 0; j < nb; j++) begin
            dr = longint'(a_rx) - longint'(prx[j]);
            dq = longint'(a_qy) - longint'(pqy[j]);
            dd = (dr > dq) ? dr - dq : dq - dr;
            if (dr <= 0 || dq <= 0 || dr > 5000 || dq > 5000 || dd > 500) continue;
            sc = dr;
            if (dq < sc) sc = dq;
            if (a_w < sc) sc = a_w;
            gap = ((dd * a_coef) >> 8) + (flog2(dd) / 2);
            cand = longint'(pf[j]) + sc - gap;
            if (cand > 64'sd2147483647) cand = 64'sd2147483647;
            if (cand < -64'sd2147483648) cand = -64'sd2147483648;
            if (cand > best) begin
                best = cand;
                idx = j;
                fnd = 1;
            end
        end
        s = best;
    endtask

    task automatic send_cur(input string nm, output bit ok);
        int t = 0;
        cur_rx = a_rx; cur_qy = a_qy; cur_w = a_w;
        gap_coef = 16'(a_coef); cur_npred = 7'(a_np);
        cur_valid = 1'b1;
        @(negedge clk);
        while (!cur_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = cur_ready;
        if (!ok) chk({nm, "_cur_ready_timeout"}, longint'(cur_ready), 1);
        @(posedge clk);
        #1 cur_valid = 1'b0;
    endtask

    task automatic send_pred(input string nm, input int j, output bit ok);
        int t = 0;
        pred_rx = prx[j]; pred_qy = pqy[j]; pred_f = pf[j];
        pred_valid = 1'b1;
        @(negedge clk);
        while (!pred_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = pred_ready;
        if (!ok) chk({nm, "_pred_ready_timeout"}, longint'(pred_ready), 1);
        @(posedge clk);
        #1 pred_valid = 1'b0;
    endtask

    task automatic finish_anchor(input string nm, input longint es, input int ei,
                                 input int ef, input int el, input int hold);
        int lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!res_valid && lat < 200);
        chk({nm, "_latency"}, lat, el);
        chk({nm, "_score"}, longint'(res_score), es);
        chk({nm, "_idx"}, longint'(res_idx), ei);
        chk({nm, "_found"}, longint'(res_found), ef);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_hold%0d_valid", nm, k), longint'(res_valid), 1);
            chk($sformatf("%s_hold%0d_score", nm, k), longint'(res_score), es);
            chk($sformatf("%s_hold%0d_cur_ready", nm, k), longint'(cur_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic run_anchor(input string nm, input longint es, input int ei,
                              input int ef, input int el, input int hold);
        bit ok;
        int nb;
        send_cur(nm, ok);
        if (!ok) return;
        nb = (a_np > 64) ? 64 : a_np;
        for (int j = 0; j < nb; j++) begin
            send_pred(nm, j, ok);
            if (!ok) return;
        end
        finish_anchor(nm, es, ei, ef, el, hold);
    endtask

    task automatic load_vec(input int i);
        a_rx = tbl[i].rx; a_qy = tbl[i].qy; a_w = tbl[i].w;
        a_coef = tbl[i].coef; a_np = tbl[i].np;
        prx[0] = tbl[i].x0; pqy[0] = tbl[i].y0; pf[0] = tbl[i].f0;
        prx[1] = tbl[i].x1; pqy[1] = tbl[i].y1; pf[1] = tbl[i].f1;
        prx[2] = tbl[i].x2; pqy[2] = tbl[i].y2; pf[2] = tbl[i].f2;
    endtask

    initial begin
        longint es;
        int ei, ef;
        bit ok;

        tbl[0] = '{100, 50, 15, 102, 1,  70, 20, 30,  0, 0, 0,  0, 0, 0,  45, 0, 1, 4};
        tbl[1] = '{100, 50, 15, 102, 1,  60, 30, 30,  0, 0, 0,  0, 0, 0,  36, 0, 1, 4};
        tbl[2] = '{100, 50, 15, 102, 3,  60, 30, 30,  110, 40, 99,  70, 20, 30,  45, 2, 1, 4};
        tbl[3] = '{100, 50, 15, 102, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  15, 63, 0, 2};
        tbl[4] = '{100, 50, 15, 102, 2,  70, 20, 30,  70, 20, 30,  0, 0, 0,  45, 0, 1, 4};
        tbl[5] = '{100, 50, 15, 102, 1,  70, 20, 2147483638,  0, 0, 0,  0, 0, 0,
                   2147483647, 0, 1, 4};
        tbl[6] = '{100, 50, 15, 102, 3,  100, 50, 500,  99, -1000, 500,  -4901, -4950, 500,
                   15, 63, 0, 4};
        tbl[7] = '{100, 50, 15, 102, 1,  70, 20, -100,  0, 0, 0,  0, 0, 0,  15, 63, 0, 4};
        tbl[8] = '{100, 50, 15, 102, 2,  -4900, -4950, 1,  -600, -150, 300,  0, 0, 0,
                   112, 1, 1, 4};

        rst_n = 1'b0;
        cur_valid = 0; cur_rx = 0; cur_qy = 0; cur_w = 0; cur_npred = 0; gap_coef = 0;
        pred_valid = 0; pred_rx = 0; pred_qy = 0; pred_f = 0; res_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cur_ready", longint'(cur_ready), 0);
        chk("rst_pred_ready", longint'(pred_ready), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_res_score", longint'(res_score), 0);
        chk("rst_res_idx", longint'(res_idx), 0);
        chk("rst_res_found", longint'(res_found), 0);
        rst_n = 1'b1;
        #1 chk("rel_cur_ready_before_edge", longint'(cur_ready), 0);
        @(posedge clk);
        #1 chk("rel_cur_ready_after_edge", longint'(cur_ready), 1);

        for (int i = 0; i < 9; i++) begin
            load_vec(i);
            run_anchor($sformatf("vec%0d", i), tbl[i].es, tbl[i].ei, tbl[i].ef, tbl[i].el, 0);
        end

        load_vec(0);
        run_anchor("backpressure", 45, 0, 1, 4, 5);

        load_vec(2);
        send_cur("midrst", ok);
        send_pred("midrst", 0, ok);
        send_pred("midrst", 1, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cur_ready", longint'(cur_ready), 0);
        chk("midrst_pred_ready", longint'(pred_ready), 0);
        chk("midrst_res_valid", longint'(res_valid), 0);
        chk("midrst_res_score", longint'(res_score), 0);
        chk("midrst_res_idx", longint'(res_idx), 0);
        chk("midrst_res_found", longint'(res_found), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_vec(0);
        run_anchor("after_rst", 45, 0, 1, 4, 0);

        for (int n = 0; n < 40; n++) begin
            a_rx = int'($urandom_range(10000, 100000));
            a_qy = int'($urandom_range(10000, 100000));
            a_w = int'($urandom_range(1, 300));
            a_coef = int'($urandom_range(0, 1000));
            a_np = (n == 20) ? 100 : int'($urandom_range(0, 6));
            for (int j = 0; j < 64; j++) begin
                prx[j] = a_rx + 100 - int'($urandom_range(0, 900));
                if ($urandom_range(0, 9) == 0) prx[j] = a_rx - int'($urandom_range(4990, 5010));
                pqy[j] = a_qy - (a_rx - prx[j]) + int'($urandom_range(0, 1200)) - 600;
                pf[j] = int'($urandom_range(0, 4000)) - 2000;
            end
            model(es, ei, ef);
            run_anchor($sformatf("rand%0d", n), es, ei, ef, (a_np == 0) ? 2 : 4, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
